sobel_window_gen: RTL and testbench

SOBEL_WINDOW_GEN -- requirements
Module: sobel_window_gen

---
 rtl/sobel_pkg.sv | 22 ++
 rtl/sobel_line_buf.sv | 24 ++
 rtl/sobel_window_gen.sv | 134 +++++++++++++
 tb/tb_sobel_window_gen.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared constants and FSM encoding for the sobel blocks
package sobel_pkg;

  // Default pixel width
  localparam int PIX_W = 8;

  // 3x3 window geometry; slot k = 3*row + col
  localparam int WIN_DIM     = 3;
  localparam int WIN_SLOTS   = WIN_DIM * WIN_DIM;
  localparam int SLOT_CENTRE = 4;
  localparam int SLOT_TOP_R  = 2;
  localparam int SLOT_MID_R  = 5;
  localparam int SLOT_BOT_R  = 8;

  // Frame progress: FILL while row < 2, STREAM once windows can form, DONE for one cycle
  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/sobel_line_buf.sv
// rtl/sobel_line_buf.sv - one-line pixel store, async read, sync write
module sobel_line_buf #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write on the clock edge; the combinational read below sees the old value first
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/sobel_window_gen.sv
// rtl/sobel_window_gen.sv - raster stream to 3x3 sliding window generator
module sobel_window_gen #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int PIX_W = sobel_pkg::PIX_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [PIX_W-1:0]                data_i,
  input  logic                            data_valid_i,
  output logic [sobel_pkg::WIN_SLOTS*PIX_W-1:0] win_o,
  output logic                            win_valid_o,
  output logic [$clog2(IMG_W)-1:0]        win_x_o,
  output logic [$clog2(IMG_H)-1:0]        win_y_o,
  output logic                            frame_done_o
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int WW = sobel_pkg::WIN_SLOTS * PIX_W;
  localparam logic [XW-1:0] COL_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] ROW_LAST = YW'(IMG_H - 1);

  logic [XW-1:0]     col_q, col_d;
  logic [YW-1:0]     row_q, row_d;
  sobel_pkg::state_e state_q;
  logic [PIX_W-1:0]  lb0_rd, lb1_rd;
  logic [WW-1:0]     win_q, win_d, win_out_q;
  logic              win_valid_q, frame_done_q;
  logic [XW-1:0]     win_x_q;
  logic [YW-1:0]     win_y_q;
  logic              accept, col_wrap, frame_last, win_hit;

  assign accept     = data_valid_i;
  assign col_wrap   = (col_q == COL_LAST);
  assign frame_last = col_wrap && (row_q == ROW_LAST);
  // A full window exists once the current pixel has two columns and two rows behind it
  assign win_hit    = accept && (col_q >= XW'(2)) && (row_q >= YW'(2));

  // Line 0 holds the previous row, line 1 the row before that
  sobel_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_line0 (
    .clk     (clk),
    .we_i    (accept),
    .addr_i  (col_q),
    .wdata_i (data_i),
    .rdata_o (lb0_rd)
  );

  sobel_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_line1 (
    .clk     (clk),
    .we_i    (accept),
    .addr_i  (col_q),
    .wdata_i (lb0_rd),
    .rdata_o (lb1_rd)
  );

  // Raster position advance: col wraps into row, row wraps at end of frame
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_wrap) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + YW'(1);
      end else begin
        col_d = col_q + XW'(1);
      end
    end
  end

  // Shift every window row left and load the new column {two lines up, one line up, current}
  always_comb begin
    win_d = win_q;
    for (int r = 0; r < sobel_pkg::WIN_DIM; r++) begin
      win_d[PIX_W*(3*r) +: PIX_W]     = win_q[PIX_W*(3*r+1) +: PIX_W];
      win_d[PIX_W*(3*r+1) +: PIX_W]   = win_q[PIX_W*(3*r+2) +: PIX_W];
    end
    win_d[PIX_W*sobel_pkg::SLOT_TOP_R +: PIX_W] = lb1_rd;
    win_d[PIX_W*sobel_pkg::SLOT_MID_R +: PIX_W] = lb0_rd;
    win_d[PIX_W*sobel_pkg::SLOT_BOT_R +: PIX_W] = data_i;
  end

  // Position counters, frame FSM and end-of-frame pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q        <= '0;
      row_q        <= '0;
      state_q      <= sobel_pkg::ST_FILL;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      frame_done_q <= accept && frame_last;
      case (state_q)
        sobel_pkg::ST_FILL:
          if (accept && col_wrap && (row_q == YW'(1))) state_q <= sobel_pkg::ST_STREAM;
        sobel_pkg::ST_STREAM:
          if (accept && frame_last) state_q <= sobel_pkg::ST_DONE;
        sobel_pkg::ST_DONE:
          state_q <= sobel_pkg::ST_FILL;
        default:
          state_q <= sobel_pkg::ST_FILL;
      endcase
    end
  end

  // Window shift register and held output window with its centre coordinates
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_q       <= '0;
      win_out_q   <= '0;
      win_valid_q <= 1'b0;
      win_x_q     <= '0;
      win_y_q     <= '0;
    end else begin
      win_valid_q <= win_hit;
      if (accept) begin
        win_q <= win_d;
      end
      if (win_hit) begin
        win_out_q <= win_d;
        win_x_q   <= col_q - XW'(1);
        win_y_q   <= row_q - YW'(1);
      end
    end
  end

  assign win_o        = win_out_q;
  assign win_valid_o  = win_valid_q;
  assign win_x_o      = win_x_q;
  assign win_y_o      = win_y_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_sobel_window_gen.sv
// tb/tb_sobel_window_gen.sv - directed self-checking bench for sobel_window_gen
module tb_sobel_window_gen;

  localparam int W = 4;
  localparam int H = 4;
  localparam int P = 8;

  logic          clk;
  logic          rst;
  logic [P-1:0]  data_i;
  logic          data_valid_i;
  logic [9*P-1:0] win_o;
  logic          win_valid_o;
  logic [1:0]    win_x_o;
  logic [1:0]    win_y_o;
  logic          frame_done_o;

  sobel_window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(P)) dut (
    .clk          (clk),
    .rst          (rst),
    .data_i       (data_i),
    .data_valid_i (data_valid_i),
    .win_o        (win_o),
    .win_valid_o  (win_valid_o),
    .win_x_o      (win_x_o),
    .win_y_o      (win_y_o),
    .frame_done_o (frame_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int slot[9];
    bit done;
  } exp_t;

  typedef struct {
    int          x;
    int          y;
    logic [71:0] win;
    bit          done;
  } cap_t;

  exp_t tbl[4];
  cap_t cap_q[$];
  int   checks = 0;
  int   errors = 0;
  int   fd_cnt = 0;
  int   consec_cnt = 0;
  bit   prev_valid = 1'b0;

  // Capture every emitted window on the falling edge
  always @(negedge clk) begin
    cap_t c;
    if (win_valid_o) begin
      c.x    = int'(win_x_o);
      c.y    = int'(win_y_o);
      c.win  = win_o;
      c.done = frame_done_o;
      cap_q.push_back(c);
      if (prev_valid) consec_cnt++;
    end
    if (frame_done_o) fd_cnt++;
    prev_valid = win_valid_o;
  end

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_capture();
    cap_q.delete();
    fd_cnt = 0;
    consec_cnt = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      data_valid_i = 1'b0;
    end
  endtask

  task automatic send_pixels(input int start, input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      data_i = P'(start + i);
      data_valid_i = 1'b1;
      if (gap) begin
        @(negedge clk);
        data_valid_i = 1'b0;
      end
    end
    @(negedge clk);
    data_valid_i = 1'b0;
  endtask

  task automatic check_windows(input string tag, input int nframes);
    logic [71:0] exp_win;
    exp_t e;
    int n;
    check({tag, "_count"}, 72'(cap_q.size()), 72'(4 * nframes));
    n = (cap_q.size() < 4 * nframes) ? cap_q.size() : 4 * nframes;
    for (int i = 0; i < n; i++) begin
      e = tbl[i % 4];
      for (int k = 0; k < 9; k++) exp_win[8*k +: 8] = 8'(e.slot[k] + 16 * (i / 4));
      check($sformatf("%s_x%0d", tag, i), 72'(cap_q[i].x), 72'(e.x));
      check($sformatf("%s_y%0d", tag, i), 72'(cap_q[i].y), 72'(e.y));
      check($sformatf("%s_win%0d", tag, i), cap_q[i].win, exp_win);
      check($sformatf("%s_done%0d", tag, i), 72'(cap_q[i].done), 72'(e.done));
    end
  endtask

  initial begin
    tbl[0] = '{x: 1, y: 1, slot: '{0, 1, 2, 4, 5, 6, 8, 9, 10},     done: 1'b0};
    tbl[1] = '{x: 2, y: 1, slot: '{1, 2, 3, 5, 6, 7, 9, 10, 11},    done: 1'b0};
    tbl[2] = '{x: 1, y: 2, slot: '{4, 5, 6, 8, 9, 10, 12, 13, 14},  done: 1'b0};
    tbl[3] = '{x: 2, y: 2, slot: '{5, 6, 7, 9, 10, 11, 13, 14, 15}, done: 1'b1};

    rst = 1'b0;
    data_i = '0;
    data_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_valid", 72'(win_valid_o), 72'(0));
    check("reset_done", 72'(frame_done_o), 72'(0));
    check("reset_win", win_o, 72'(0));
    check("reset_xy", 72'({win_x_o, win_y_o}), 72'(0));
    rst = 1'b1;
    idle(2);

    // Continuous single frame
    clear_capture();
    send_pixels(0, 16, 1'b0);
    idle(3);
    check_windows("cont", 1);
    check("cont_fd", 72'(fd_cnt), 72'(1));
    check("hold_win", win_o, cap_q[cap_q.size()-1].win);

    // Every other cycle idle
    clear_capture();
    send_pixels(0, 16, 1'b1);
    idle(3);
    check_windows("gap", 1);
    check("gap_consec", 72'(consec_cnt), 72'(0));
    check("gap_fd", 72'(fd_cnt), 72'(1));

    // Two frames back to back
    clear_capture();
    send_pixels(0, 32, 1'b0);
    idle(3);
    check_windows("b2b", 2);
    check("b2b_fd", 72'(fd_cnt), 72'(2));

    // Reset mid-frame with valid toggling while held
    clear_capture();
    send_pixels(0, 9, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      data_i = 8'hAA;
      data_valid_i = i[0];
      check($sformatf("rst_hold%0d", i),
            {win_o[67:0], win_valid_o, frame_done_o, win_x_o != 0, win_y_o != 0}, 72'(0));
    end
    data_valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("abort_none", 72'(cap_q.size()), 72'(0));
    check("abort_fd", 72'(fd_cnt), 72'(0));
    send_pixels(0, 10, 1'b0);
    check("pre_window", 72'(cap_q.size()), 72'(0));
    send_pixels(10, 6, 1'b0);
    idle(3);
    check_windows("rst", 1);
    check("rst_fd", 72'(fd_cnt), 72'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
